// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - pose and jump-phase types plus screen geometry for player 1
package state_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RIGHT1 = 2'd1,
    LEFT1  = 2'd2
  } State;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  localparam int SPRITE_W = 40;
  localparam int H_ACTIVE = 640;

endpackage

// File: rtl/player1_ctl_if.sv
// rtl/player1_ctl_if.sv - frame sync, key levels and sprite outputs between pads and drawer
interface player1_ctl_if;
  import state_pkg::*;

  logic        vsync;
  logic        key_left;
  logic        key_right;
  logic        key_jump;
  logic [11:0] xpos_player1;
  logic [11:0] ypos_player1;
  State        state;

  modport master (
    output vsync, key_left, key_right, key_jump,
    input  xpos_player1, ypos_player1, state
  );

  modport slave (
    input  vsync, key_left, key_right, key_jump,
    output xpos_player1, ypos_player1, state
  );

endinterface

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchroniser for one asynchronous key level
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/player1_ctl.sv
// rtl/player1_ctl.sv - per-frame pose, x move and optional jump for player 1
// PLAYER1_JUMP_EN compiles in the jump FSM; otherwise ypos_player1 stays 0.
module player1_ctl
  import state_pkg::*;
#(
  parameter int X_START = 300,
  parameter int X_MAX   = H_ACTIVE - SPRITE_W,
  parameter int STEP    = 2,
  parameter int JUMP_V  = 12
) (
  input logic         clk,
  input logic         rst_n,
  player1_ctl_if.slave bus
);

  if (STEP < 1 || STEP > 15) begin : g_bad_step
    $error("player1_ctl: STEP must be 1..15");
  end
  if (JUMP_V < 1 || JUMP_V > 31) begin : g_bad_jump_v
    $error("player1_ctl: JUMP_V must be 1..31");
  end

  logic key_left_s;
  logic key_right_s;

  key_sync u_sync_left (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.key_left),
    .q_o   (key_left_s)
  );

  key_sync u_sync_right (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.key_right),
    .q_o   (key_right_s)
  );

  logic vsync_q;
  logic tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= bus.vsync;
  end

  assign tick = bus.vsync & ~vsync_q;

  State        pose_q, pose_d, pose_sel;
  logic [11:0] x_q, x_d;
  logic [12:0] x_sum;

  always_comb begin
    pose_sel = IDLE;
    if (key_right_s && !key_left_s)      pose_sel = RIGHT1;
    else if (key_left_s && !key_right_s) pose_sel = LEFT1;
  end

  // Sum is formed in 13 bits so the right-hand clamp sees any carry.
  always_comb begin
    pose_d = pose_q;
    x_d    = x_q;
    x_sum  = {1'b0, x_q} + 13'(STEP);
    if (tick) begin
      pose_d = pose_sel;
      case (pose_sel)
        RIGHT1:  x_d = (x_sum > 13'(X_MAX)) ? 12'(X_MAX) : x_sum[11:0];
        LEFT1:   x_d = (x_q < 12'(STEP)) ? 12'd0 : x_q - 12'(STEP);
        default: x_d = x_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pose_q <= IDLE;
      x_q    <= 12'(X_START);
    end else begin
      pose_q <= pose_d;
      x_q    <= x_d;
    end
  end

  assign bus.xpos_player1 = x_q;
  assign bus.state        = pose_q;

`ifdef PLAYER1_JUMP_EN
  logic        key_jump_s;
  jump_state_t jump_q, jump_d;
  logic [4:0]  v_q, v_d, v_inc;
  logic [11:0] y_q, y_d;
  logic [12:0] y_sum;

  key_sync u_sync_jump (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.key_jump),
    .q_o   (key_jump_s)
  );

  always_comb begin
    jump_d = jump_q;
    v_d    = v_q;
    y_d    = y_q;
    y_sum  = {1'b0, y_q} + 13'(v_q);
    v_inc  = v_q + 5'd1;
    if (tick) begin
      case (jump_q)
        GROUND: begin
          if (key_jump_s) begin
            jump_d = RISE;
            v_d    = 5'(JUMP_V);
          end
        end
        RISE: begin
          y_d = (y_sum > 13'h0FFF) ? 12'hFFF : y_sum[11:0];
          v_d = v_q - 5'd1;
          if (v_q == 5'd1) jump_d = FALL;
        end
        FALL: begin
          // Landing test precedes the subtraction so y never wraps below the floor.
          if ({7'd0, v_inc} >= y_q) begin
            y_d    = 12'd0;
            v_d    = 5'd0;
            jump_d = GROUND;
          end else begin
            y_d = y_q - {7'd0, v_inc};
            v_d = v_inc;
          end
        end
        default: begin
          jump_d = GROUND;
          v_d    = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_q <= GROUND;
      v_q    <= 5'd0;
      y_q    <= 12'd0;
    end else begin
      jump_q <= jump_d;
      v_q    <= v_d;
      y_q    <= y_d;
    end
  end

  assign bus.ypos_player1 = y_q;
`else
  assign bus.ypos_player1 = 12'd0;
`endif

endmodule

// File: tb/tb_player1_ctl.sv
// tb/tb_player1_ctl.sv - randomized frame-level bench for player1_ctl against a trajectory model
module tb_player1_ctl;
  import state_pkg::*;

  localparam int XS = 300;
  localparam int XM = 600;
  localparam int ST = 2;
  localparam int JV = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player1_ctl_if bus ();

  player1_ctl #(.X_START(XS), .X_MAX(XM), .STEP(ST), .JUMP_V(JV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int mx;
  int my;
  int mpose;
  int jn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, {20'd0, bus.xpos_player1}, mx);
    check({tag, "_y"}, {20'd0, bus.ypos_player1}, my);
    check({tag, "_state"}, {30'd0, bus.state}, mpose);
  endtask

  // Height n ticks after launch: triangular rise to the peak, then triangular fall.
  function automatic int jump_height(input int n);
    int peak;
    int k;
    peak = JV * (JV + 1) / 2;
    if (n <= JV) return n * JV - n * (n - 1) / 2;
    k = n - JV;
    return (peak - k * (k + 1) / 2 < 0) ? 0 : peak - k * (k + 1) / 2;
  endfunction

  task automatic model_reset();
    mx    = XS;
    my    = 0;
    mpose = 0;
    jn    = -1;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    if (r && !l)      mpose = 1;
    else if (l && !r) mpose = 2;
    else              mpose = 0;
    if (mpose == 1) mx = (mx + ST > XM) ? XM : mx + ST;
    if (mpose == 2) mx = (mx - ST < 0) ? 0 : mx - ST;
`ifdef PLAYER1_JUMP_EN
    if (jn < 0) begin
      if (j) jn = 0;
    end else begin
      jn++;
      my = jump_height(jn);
      if (jn == 2 * JV) jn = -1;
    end
`else
    if (j) my = 0;
`endif
  endtask

  task automatic do_frame(input bit l, input bit r, input bit j, input bit toggle);
    bus.key_left  = l;
    bus.key_jump  = j;
    bus.key_right = toggle ? ~r : r;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (toggle && c < 3) bus.key_right = 1'($urandom_range(0, 1));
      if (c == 3) bus.key_right = r;
      check_outputs("stable");
    end
    bus.vsync = 1'b1;
    @(posedge clk);
    #1;
    bus.vsync = 1'b0;
    model_tick(l, r, j);
    check_outputs("tick");
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.vsync     = 1'b0;
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    for (int f = 0; f < 5; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 160; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check("right_edge_x", {20'd0, bus.xpos_player1}, 32'd600);
    check("right_edge_state", {30'd0, bus.state}, 32'd1);

    for (int f = 0; f < 310; f++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("left_edge_x", {20'd0, bus.xpos_player1}, 32'd0);
    check("left_edge_state", {30'd0, bus.state}, 32'd2);

    for (int f = 0; f < 3; f++) do_frame(1'b1, 1'b1, 1'b0, 1'b1);
    check("both_keys_x", {20'd0, bus.xpos_player1}, 32'd0);
    check("both_keys_state", {30'd0, bus.state}, 32'd0);

`ifdef PLAYER1_JUMP_EN
    do_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check("launch_y", {20'd0, bus.ypos_player1}, 32'd0);
    for (int f = 0; f < 12; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("peak_y", {20'd0, bus.ypos_player1}, 32'd78);
    for (int f = 0; f < 12; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("landed_y", {20'd0, bus.ypos_player1}, 32'd0);
    for (int f = 0; f < 3; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    for (int f = 0; f < 300; f++) begin
      do_frame(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

`ifdef PLAYER1_JUMP_EN
    for (int f = 0; f < 30 && jn >= 0; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b1, 1'b0);
    for (int f = 0; f < 30 && my != 50; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check("midjump_y_before", {20'd0, bus.ypos_player1}, 32'd50);
`else
    for (int f = 0; f < 20; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    async_reset_check("reset_async");

    for (int f = 0; f < 4; f++) do_frame(1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player1_ctl.md
# player1_ctl

Per-frame movement controller for player 1. Converts asynchronous button levels into the `xpos_player1`, `ypos_player1` and `state` signals consumed by the player sprite drawer. It updates once per video frame on the rising edge of `vsync`, so the sprite never changes position or pose mid-frame. It sits between the input pads (or keyboard decoder) and the drawing pipeline.

## Interface
Parameters:
- `X_START`, 300: horizontal position after reset.
- `X_MAX`, 600: largest allowed `xpos_player1` (640 − sprite width 40).
- `STEP`, 2: horizontal pixels moved per frame; 1..15.
- `JUMP_V`, 12: initial upward speed in pixels/frame; 1..31.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vsync`  in  1  frame sync from the VGA timing chain, synchronous to `clk`.
- `key_left`  in  1  asynchronous level, 1 = pressed.
- `key_right`  in  1  asynchronous level, 1 = pressed.
- `key_jump`  in  1  asynchronous level, 1 = pressed.
- `xpos_player1`  out  12  sprite left edge, 0..`X_MAX`.
- `ypos_player1`  out  12  height above the floor in pixels; 0 = standing.
- `state`  out  `State`  pose: `IDLE`, `RIGHT1` or `LEFT1`.

## Operation
- **Key synchronisation:** each key passes through a 2-FF synchroniser. Only the synchronised levels are used.
- **Frame tick:** `vsync_q` registers `vsync`. `tick = vsync & ~vsync_q`, which is high for exactly one cycle per frame. All outputs change only in the cycle after a `tick`.
- **Pose selection** at `tick`, from the synchronised keys:
  - right only → `RIGHT1`
  - left only → `LEFT1`
  - neither or both → `IDLE`
- **Horizontal move** at `tick`, using the pose just computed:
  - `RIGHT1`: x = min(x + `STEP`, `X_MAX`).
  - `LEFT1`: x = max(x − `STEP`, 0). Compare before subtracting so the value never wraps.
  - `IDLE`: x holds.
- **Jump FSM** (with `PLAYER1_JUMP_EN`). States are `GROUND`, `RISE`, `FALL`. A 5-bit speed register `v` is updated only at `tick`:
  - `GROUND` → `RISE` when the jump key is pressed. Set `v = JUMP_V`; y is unchanged in that tick.
  - `RISE`: y += v, then v −= 1. When v reaches 0, go to `FALL`.
  - `FALL`: v += 1, then y = max(y − v, 0). When y reaches 0, go to `GROUND` with v = 0.
  - Holding the jump key in `GROUND` re-triggers a jump on the next tick. The key is ignored in `RISE` and `FALL`.
  - Horizontal movement continues during a jump.
- **Reset values:** `xpos_player1 = X_START`, `ypos_player1 = 0`, `state = IDLE`, jump FSM in `GROUND`, `v = 0`, synchronisers and `vsync_q` at 0.
- **Reset mid-jump** returns immediately (asynchronously) to the reset values.
- **Arithmetic:** all internal adds use 13 bits and are clamped before truncation to 12 bits.

## Timing
- Key change to synchronised level: 2 cycles.
- `vsync` rising in cycle N gives `tick` in cycle N; outputs are valid from cycle N+1.
- A key must be stable for at least 3 cycles before the `vsync` edge to be reflected in that frame's update.
- Outputs are registered and stable for an entire frame.
- Peak height with `JUMP_V` = 12 is 78 (sum 12..1). The jump takes 1 launch tick + 12 `RISE` ticks + 12 `FALL` ticks.

## Configuration
- `PLAYER1_JUMP_EN` defined: jump FSM and `v` register are compiled in as described above.
- `PLAYER1_JUMP_EN` undefined: no jump logic. `ypos_player1` is constant 0. `key_jump` stays as a port but is ignored.

## Structure
- `state_pkg` keeps the existing `State` enum (`IDLE`, `RIGHT1`, `LEFT1`). Add `jump_state_t` (`GROUND`, `RISE`, `FALL`) and the constants `SPRITE_W` = 40 and `H_ACTIVE` = 640 to the same package. The default `X_MAX` is derived as `H_ACTIVE − SPRITE_W`.
- One sub-module, `key_sync`: a 2-FF synchroniser with async active-low reset, instantiated three times.

## Test plan
- **Reset:** release reset with keys idle and 5 frames run → x = 300, y = 0, `state` = `IDLE` throughout.
- **Right to edge:** hold `key_right` for 160 frames → `state` = `RIGHT1`; x rises by 2 per frame and saturates at 600, with no wrap.
- **Left to edge:** start at x = 3, hold `key_left` → x goes 1, then 0, then stays 0. Pressing both keys afterwards → `IDLE`, x holds.
- **Jump** (macro on): pulse `key_jump` for 1 frame with `JUMP_V` = 12 → y sequence 0, 12, 23, … 78, then back down to 0 after 25 ticks; FSM in `GROUND`.
- **Mid-frame stability:** toggle `key_right` between `vsync` edges → outputs change only in the cycle after a `vsync` rising edge.
- **Reset mid-jump:** assert `rst_n` = 0 at y = 50 → y = 0, x = 300, `state` = `IDLE` immediately, with no clock edge required.
